pcgen: RTL and testbench
========================

# pcgen

PC-generation stage at the head of the pipeline, directly upstream of fetch. Holds the architectural fetch PC register and drives it into fetch every cycle. Selects the next PC from boot vector, execute-stage redirect, fetch's predicted PC, or hold (stall / instruction-bus wait). Buffers a redirect that arrives mid-transaction, so the instruction-bus address stays stable until `data_ok`.

## Interface

Parameters:
- `RESET_PC`, default `64'h8000_0000`: first fetch address after reset.

Ports:
- `clk`  in  1  — single clock; all state updates on rising edge.
- `reset`  in  1  — asynchronous, active-low; asserting it (0) clears all state immediately.
- `imem_wait`  in  1  — fetch has an outstanding instruction-bus request not yet `data_ok`.
- `predPC`  in  64  — predicted next PC from fetch (type u64).
- `stall`  in  1  — hazard-unit stall of the F/D boundary.
- `redirect_valid`  in  1  — execute resolved a mispredict/jump this cycle.
- `redirect_pc`  in  64  — corrected target, valid with `redirect_valid`.
- `pc`  out  64  — current fetch PC; 0 means "no request".
- `flushF`  out  1  — the fetch output this cycle is wrong-path; the F/D register must not capture it.

## Operation

- State machine `pcgen_state_t`: BOOT, RUN, HOLD_REDIR. Registers: `pc_q` (64), `pend_q` (64), `state_q`.
- Reset (`reset`=0): `pc_q`=0, `pend_q`=0, `state_q`=BOOT. Outputs during reset: `pc`=0, `flushF`=0.
- BOOT: `pc_q`<=RESET_PC, go to RUN. `redirect_valid`, `stall` and `imem_wait` are ignored. `flushF`=0.
- RUN, priority order:
  - `redirect_valid` && !`imem_wait`: `pc_q`<=`redirect_pc`; `flushF`=1.
  - `redirect_valid` && `imem_wait`: `pend_q`<=`redirect_pc`; `pc_q` held; go to HOLD_REDIR; `flushF`=1.
  - `imem_wait` || `stall`: hold `pc_q`; `flushF`=0.
  - Otherwise: `pc_q`<=`predPC`; `flushF`=0.
- HOLD_REDIR:
  - `pc_q` is held regardless of `stall`.
  - `flushF`=1 every cycle.
  - A new `redirect_valid` overwrites `pend_q`; the latest redirect wins.
  - When `imem_wait`=0:
    - `pc_q`<=`redirect_pc` if `redirect_valid` this cycle, else `pend_q`.
    - Go to RUN.
- No alignment checks. PC bits pass through unmodified; misaligned-fetch handling lives elsewhere.
- `flushF` is a combinational function of `state_q`, `redirect_valid` and `imem_wait` only.

## Timing

- `pc` is a registered output with zero combinational input-to-`pc` paths.
- Reset deassert to first request: `pc`=RESET_PC one edge after the first rising edge with `reset`=1.
- Redirect in RUN with bus idle: new `pc` on the next edge (1-cycle redirect latency).
- Redirect during a pending bus request: new `pc` on the edge of the cycle where `imem_wait` is 0. `pc` never changes while `imem_wait`=1.
- Redirect and `stall` in the same cycle: the redirect takes effect.
- Reset asserted mid-HOLD_REDIR: `pend_q` is discarded and the block returns to BOOT.

## Structure

- `pcgen_state_t` enum and `PC_RESET` constant (`64'h8000_0000`) go in the `pipes` package. `RESET_PC` defaults to `PC_RESET`.
- Uses `u64`/`u1` from `common`.
- Single flat module, no sub-module; the next-PC mux and the FSM are small enough to inline.

## Test plan

- Reset release → `pc`=0 for the first cycle, then `pc`=`64'h8000_0000`; with `imem_wait`=0 and `predPC`=`pc`+4, following cycles show `...04`, `...08`.
- `stall`=1 for 3 cycles at `pc`=`...10` → `pc` stays `...10`, `flushF`=0; release → `pc`=`predPC`.
- `redirect_valid`=1, `redirect_pc`=`...200`, `imem_wait`=0 → `flushF`=1 that cycle; `pc`=`...200` next cycle.
- `imem_wait`=1 for 4 cycles with redirect to `...300` in the 2nd cycle → `pc` unchanged and `flushF`=1 through the wait; `pc`=`...300` the cycle after `imem_wait` drops.
- Within HOLD_REDIR, second redirect to `...400`, then `imem_wait` drops concurrently with a third redirect to `...500` → `pc`=`...500`.
- `reset`=0 asserted asynchronously mid-HOLD_REDIR → `pc`=0 immediately; after release, boot sequence to `...8000_0000`, and the pending target is never issued.

Source files
------------

// File: rtl/common.sv
// Shared scalar type aliases used across the pipeline.
package common;

  typedef logic [63:0] u64;
  typedef logic        u1;

endpackage : common

// File: rtl/pipes.sv
// Pipeline-stage definitions shared by the front-end stages.
package pipes;

  import common::*;

  // Architectural boot vector: first fetch address after reset.
  localparam u64 PC_RESET = 64'h8000_0000;

  // PC-generation FSM.
  //   BOOT       : one cycle after reset, loads the boot vector.
  //   RUN        : normal sequencing (predict / redirect / hold).
  //   HOLD_REDIR : a redirect arrived while the instruction bus was busy;
  //                the target waits here until the bus transaction completes.
  typedef enum logic [1:0] {
    BOOT       = 2'd0,
    RUN        = 2'd1,
    HOLD_REDIR = 2'd2
  } pcgen_state_t;

endpackage : pipes

// File: rtl/pcgen.sv
// PC-generation stage: owns the fetch PC register, picks the next PC from
// boot vector / execute redirect / fetch prediction / hold, and parks a
// redirect that lands mid bus-transaction so the fetch address stays stable
// until the instruction bus returns data_ok.
module pcgen
  import common::*;
  import pipes::*;
#(
  parameter u64 RESET_PC = PC_RESET
) (
  input  logic        clk,
  input  logic        reset,          // asynchronous, active-low
  input  logic        imem_wait,
  input  logic [63:0] predPC,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic [63:0] pc,
  output logic        flushF
);

  pcgen_state_t state_q, state_d;
  u64           pc_q,    pc_d;
  u64           pend_q,  pend_d;

  // Next-state and next-PC selection; flushF depends only on state and the
  // redirect/bus-wait inputs, never on stall or predPC.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    flushF  = 1'b0;

    unique case (state_q)
      BOOT: begin
        pc_d    = RESET_PC;
        state_d = RUN;
      end

      RUN: begin
        if (redirect_valid && !imem_wait) begin
          pc_d   = redirect_pc;
          flushF = 1'b1;
        end else if (redirect_valid) begin
          // Bus busy: the address must not move, so park the target.
          pend_d  = redirect_pc;
          state_d = HOLD_REDIR;
          flushF  = 1'b1;
        end else if (!imem_wait && !stall) begin
          pc_d = predPC;
        end
      end

      HOLD_REDIR: begin
        // Everything fetched until the parked target issues is wrong-path.
        flushF = 1'b1;
        if (redirect_valid) begin
          pend_d = redirect_pc;
        end
        if (!imem_wait) begin
          pc_d    = redirect_valid ? redirect_pc : pend_q;
          state_d = RUN;
        end
      end

      default: begin
        state_d = BOOT;
      end
    endcase
  end

  // State registers; reset discards any parked redirect and re-enters BOOT.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of its inputs.
    if (!reset) begin
      state_q <= BOOT;
      pc_q    <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
    end
  end

  // The fetch PC is driven straight from the register: no input-to-pc paths.
  assign pc = pc_q;

endmodule : pcgen

// File: tb/tb_pcgen.sv
// Self-checking bench for pcgen: directed scenarios with literal expectations
// followed by randomized traffic, all compared every cycle against a
// behavioural model of the fetch-PC rules.
module tb_pcgen;

  localparam logic [63:0] BOOT_PC = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_wait = 1'b0;
  logic [63:0] predPC = '0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic [63:0] pc;
  logic        flushF;

  int n_checks = 0;
  int n_fail   = 0;

  pcgen dut (
    .clk            (clk),
    .reset          (reset),
    .imem_wait      (imem_wait),
    .predPC         (predPC),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .pc             (pc),
    .flushF         (flushF)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------
  // Behavioural model: "is the stage live yet", the fetch PC, and an
  // optional parked redirect target waiting for the bus to go idle.
  // ---------------------------------------------------------------------
  bit          m_live   = 1'b0;
  logic [63:0] m_pc     = '0;
  bit          m_parked = 1'b0;
  logic [63:0] m_target = '0;

  // Wrong-path marker: a redirect this cycle, or a target still parked.
  function automatic logic exp_flush();
    if (!m_live) return 1'b0;
    return m_parked || redirect_valid;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_live   <= 1'b0;
      m_pc     <= '0;
      m_parked <= 1'b0;
    end else if (!m_live) begin
      m_live <= 1'b1;
      m_pc   <= BOOT_PC;
    end else if (m_parked) begin
      if (redirect_valid) m_target <= redirect_pc;
      if (!imem_wait) begin
        m_pc     <= redirect_valid ? redirect_pc : m_target;
        m_parked <= 1'b0;
      end
    end else if (redirect_valid) begin
      if (imem_wait) begin
        m_parked <= 1'b1;
        m_target <= redirect_pc;
      end else begin
        m_pc <= redirect_pc;
      end
    end else if (!imem_wait && !stall) begin
      m_pc <= predPC;
    end
  end

  // Per-cycle comparison, mid-cycle while inputs and outputs are stable.
  always @(negedge clk) begin
    check("model_pc", pc, m_pc);
    check("model_flushF", {63'd0, flushF}, {63'd0, exp_flush()});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    imem_wait      = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
  endtask

  initial begin
    // Reset held for a few cycles.
    repeat (3) step();
    check("reset_pc", pc, 64'h0);
    check("reset_flushF", {63'd0, flushF}, 64'h0);

    // Release: pc 0 for the first cycle, boot vector after the next edge.
    reset = 1'b1;
    predPC = 64'h0000_0000_dead_beef;
    #1;
    check("first_cycle_pc", pc, 64'h0);
    step();
    check("boot_pc", pc, 64'h8000_0000);
    predPC = m_pc + 64'd4;
    step();
    check("seq_pc_04", pc, 64'h8000_0004);
    predPC = m_pc + 64'd4;
    step();
    check("seq_pc_08", pc, 64'h8000_0008);
    predPC = m_pc + 64'd4;
    step();
    predPC = m_pc + 64'd4;
    step();
    check("seq_pc_10", pc, 64'h8000_0010);

    // Stall for three cycles holds pc with no flush.
    predPC = m_pc + 64'd4;
    stall  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_pc", pc, 64'h8000_0010);
      check("stall_flushF", {63'd0, flushF}, 64'h0);
    end
    stall = 1'b0;
    step();
    check("stall_release_pc", pc, 64'h8000_0014);

    // Redirect with bus idle: flush now, new pc next edge.
    redirect_valid = 1'b1;
    redirect_pc    = 64'h0000_0000_0000_0200;
    stall          = 1'b1;
    #1;
    check("redir_flushF", {63'd0, flushF}, 64'h1);
    step();
    check("redir_pc", pc, 64'h200);
    idle_inputs();

    // Bus wait of 4 cycles, redirect to 0x300 in the 2nd.
    imem_wait = 1'b1;
    predPC    = 64'h0000_0000_0000_0999;
    step();
    check("wait1_pc", pc, 64'h200);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h300;
    #1;
    check("wait2_flushF", {63'd0, flushF}, 64'h1);
    step();
    redirect_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("wait_hold_pc", pc, 64'h200);
      check("wait_hold_flushF", {63'd0, flushF}, 64'h1);
      step();
    end
    imem_wait = 1'b0;
    #1;
    check("wait_drop_flushF", {63'd0, flushF}, 64'h1);
    step();
    check("wait_redir_pc", pc, 64'h300);

    // Latest redirect wins while parked.
    imem_wait      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h350;
    step();
    redirect_pc = 64'h400;
    step();
    check("hold_multi_pc", pc, 64'h300);
    imem_wait   = 1'b0;
    redirect_pc = 64'h500;
    step();
    check("latest_wins_pc", pc, 64'h500);
    idle_inputs();
    step();

    // Async reset while a target is parked: target discarded.
    imem_wait      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h600;
    step();
    redirect_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check("async_reset_pc", pc, 64'h0);
    check("async_reset_flushF", {63'd0, flushF}, 64'h0);
    step();
    idle_inputs();
    reset  = 1'b1;
    predPC = 64'h0000_0000_0000_0600;
    step();
    check("reboot_pc", pc, 64'h8000_0000);
    predPC = m_pc + 64'd4;
    step();
    check("no_stale_target_pc", pc, 64'h8000_0004);

    // Randomized traffic, model-checked every cycle.
    for (int i = 0; i < 600; i++) begin
      @(posedge clk);
      #1;
      reset          = 1'b1;
      imem_wait      = ($urandom_range(99) < 40);
      stall          = ($urandom_range(99) < 20);
      redirect_valid = ($urandom_range(99) < 15);
      redirect_pc    = {$urandom, $urandom};
      predPC         = ($urandom_range(3) == 0) ? {$urandom, $urandom} : m_pc + 64'd4;
      if ($urandom_range(79) == 0) begin
        #2;
        reset = 1'b0;
      end
    end
    reset = 1'b1;
    idle_inputs();
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_pcgen
